bullet_controller: RTL and testbench
====================================

# bullet_controller

Frame-rate controller that drives the sigSpawn/sigBounce/sigKill inputs of a pool of Bullet instances. It turns the tank's fire button into spawn commands for free slots, issues bounces on arena-edge contact, and issues kills on enemy hits. It sits between the tank entity and the bullet pool in the game-logic layer, clocked by the frame clock.

## Interface
- NUM_BULLETS, 4: bullet slots managed; slot i uses bit i / bits [10i+9:10i] of the vector ports.
- COOLDOWN, 8'd15: frames after a spawn during which fire requests are dropped.
- SPAWN_OFFSET, 10'd12: start distance from the tank centre along tankDir.
- ARENA_MIN_X / ARENA_MAX_X, 10'd8 / 10'd631: horizontal bounce limits.
- ARENA_MIN_Y / ARENA_MAX_Y, 10'd8 / 10'd471: vertical bounce limits.
- BOUNCE_HOLDOFF, 3: frames a slot is ineligible for another bounce after one is issued.
- frameClk  in  1  frame clock; the block's only clock.
- resetN  in  1  asynchronous, active-low reset.
- fireReq  in  1  tank fire button, level.
- tankPosX, tankPosY  in  10 each  tank centre.
- tankDir  in  DIRECTION  tank facing.
- bulletExists  in  NUM_BULLETS  per-slot existence from the bullets.
- bulletPosX, bulletPosY  in  10*NUM_BULLETS each  per-slot bullet centre.
- enemyPosX, enemyPosY  in  10 each  enemy centre.
- enemyRadius  in  8  enemy half-size.
- sigSpawn, sigBounce, sigKill  out  NUM_BULLETS each  per-slot one-frame command pulses.
- bulletStartX, bulletStartY  out  10 each  start position for the slot being spawned.
- bulletStartDir  out  DIRECTION  start direction for the slot being spawned.
- hitPulse  out  1  one-frame pulse when at least one kill is issued for an enemy hit.
- fireDropped  out  1  one-frame pulse when an accepted fire edge cannot be serviced.
- hitCount  out  8  saturating count of enemy hits.

## Operation
- Fire edge: fireReq is registered, and a rising edge is fireReq=1 with the prior sample 0. Held buttons fire once.
- Free slot: the lowest index i with bulletExists[i]=0 and pendSpawn[i]=0. pendSpawn[i] is set when sigSpawn[i] is issued and cleared when bulletExists[i] is seen high or after 2 frames, whichever comes first. This covers the one-frame lag before bulletExists reflects a spawn.
- Spawn: on a fire edge with cooldown=0 and a free slot:
  - assert sigSpawn[slot] and set cooldown to COOLDOWN.
  - bulletStartDir=tankDir.
  - bulletStartX/Y = tankPos ± SPAWN_OFFSET on the tankDir axis (UP subtracts Y, DOWN adds Y, LEFT subtracts X, RIGHT adds X), computed mod 2^10 with no clamping.
- Dropped fire: a fire edge during cooldown>0, or with no free slot, pulses fireDropped. Nothing is queued.
- Cooldown counter: decrements once per frame to 0 and saturates there.
- Bounce: a slot with bulletExists=1 and holdoff=0 whose position is ≤MIN or ≥MAX on either axis gets sigBounce[i] and holdoff[i]=BOUNCE_HOLDOFF. holdoff decrements per frame.
- Hit: a slot with bulletExists=1 and |bulletPos−enemyPos| ≤ enemyRadius on both axes gets sigKill[i]. Use unsigned compare on the 11-bit absolute difference.
  - hitPulse=1 if any slot was killed.
  - hitCount+1, saturating at 255.
- Priority per slot: kill > bounce. A killed slot gets no bounce that frame and its holdoff is cleared.
- Spawn and kill/bounce can target different slots in the same frame. A slot being spawned never receives kill or bounce that frame, because it does not exist yet.

## Timing
- All outputs are registered. Decisions use values sampled at edge k; pulses are high from edge k to edge k+1, and Bullet samples them at edge k+1.
- bulletStart* are valid in the same frame as sigSpawn and hold their last value otherwise.
- Latency: fireReq rise sampled at edge k → sigSpawn high after edge k+1.
- Bounce: position at limit at edge k → sigBounce after edge k. With BOUNCE_HOLDOFF=3, the bullet stays at or beyond the limit for up to 2 more frames without a re-bounce.
- Reset (resetN=0, any time, async):
  - all pulse outputs, bulletStart*, hitCount, cooldown, holdoff and pendSpawn go to 0; bulletStartDir goes to RIGHT.
  - the fire-edge register goes to 1, so a button held through reset does not fire.
- The first edge after reset deassertion is processed normally.

## Test plan
- Reset, then fireReq 0→1 with tank at (100,200) RIGHT and all slots empty → sigSpawn=4'b0001 for one frame, start=(112,200), RIGHT; hold fireReq 20 frames → no further spawn.
- Fire edges 5 frames apart with COOLDOWN=15 → second edge gives fireDropped=1 and no sigSpawn. A fire edge 16 frames after the first → sigSpawn to the next free slot (4'b0010 while slot 0 exists).
- bulletExists=4'b1111, fire edge → fireDropped=1 and sigSpawn=0. Then slot 2 exists→0 → next fire spawns slot 2.
- Slot 1 at X=631 for 4 consecutive frames → sigBounce[1] in frame 1 only, again in frame 4 once holdoff expires.
- Slot 0 at enemy position and at X=8 in the same frame → sigKill[0]=1, sigBounce[0]=0, hitPulse=1, hitCount 0→1. Force 300 hits → hitCount saturates at 255.
- Tank at (5,5) facing UP → bulletStartY=1017 (wrap). resetN pulsed low mid-cooldown → outputs are 0 immediately, and a fire edge right after release spawns slot 0.

Source files
------------

// File: rtl/bullet_controller.sv
// Frame-rate bullet pool controller: turns fire edges into spawns for free slots,
// and issues per-slot bounce and kill pulses from arena-edge and enemy-hit checks.
module bullet_controller #(
    parameter int          NUM_BULLETS    = 4,
    parameter logic [7:0]  COOLDOWN       = 8'd15,
    parameter logic [9:0]  SPAWN_OFFSET   = 10'd12,
    parameter logic [9:0]  ARENA_MIN_X    = 10'd8,
    parameter logic [9:0]  ARENA_MAX_X    = 10'd631,
    parameter logic [9:0]  ARENA_MIN_Y    = 10'd8,
    parameter logic [9:0]  ARENA_MAX_Y    = 10'd471,
    parameter int          BOUNCE_HOLDOFF = 3
) (
    input  logic                      frameClk,
    input  logic                      resetN,
    input  logic                      fireReq,
    input  logic [9:0]                tankPosX,
    input  logic [9:0]                tankPosY,
    input  logic [1:0]                tankDir,
    input  logic [NUM_BULLETS-1:0]    bulletExists,
    input  logic [10*NUM_BULLETS-1:0] bulletPosX,
    input  logic [10*NUM_BULLETS-1:0] bulletPosY,
    input  logic [9:0]                enemyPosX,
    input  logic [9:0]                enemyPosY,
    input  logic [7:0]                enemyRadius,
    output logic [NUM_BULLETS-1:0]    sigSpawn,
    output logic [NUM_BULLETS-1:0]    sigBounce,
    output logic [NUM_BULLETS-1:0]    sigKill,
    output logic [9:0]                bulletStartX,
    output logic [9:0]                bulletStartY,
    output logic [1:0]                bulletStartDir,
    output logic                      hitPulse,
    output logic                      fireDropped,
    output logic [7:0]                hitCount
);

    localparam int                HOLD_W    = $clog2(BOUNCE_HOLDOFF + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(BOUNCE_HOLDOFF);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    logic                   fire_q;
    logic                   fire_prev;
    logic [7:0]             cooldown;
    logic [HOLD_W-1:0]      holdoff   [NUM_BULLETS];
    logic [1:0]             pend_cnt  [NUM_BULLETS];

    logic                   fire_edge;
    logic                   free_found;
    logic                   spawn_ok;
    logic [NUM_BULLETS-1:0] free_vec;
    logic [NUM_BULLETS-1:0] spawn_vec;
    logic [NUM_BULLETS-1:0] kill_vec;
    logic [NUM_BULLETS-1:0] bounce_vec;
    logic [HOLD_W-1:0]      hold_eff  [NUM_BULLETS];
    logic [9:0]             start_x;
    logic [9:0]             start_y;

    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    function automatic logic at_limit(input logic [9:0] x, input logic [9:0] y);
        return (x <= ARENA_MIN_X) || (x >= ARENA_MAX_X) ||
               (y <= ARENA_MIN_Y) || (y >= ARENA_MAX_Y);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        fire_edge  = fire_q & ~fire_prev;
        free_vec   = '0;
        free_found = 1'b0;
        // A just-spawned slot stays reserved until its bullet reports existence.
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!free_found && !bulletExists[i] && pend_cnt[i] == 2'd0) begin
                free_vec[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
        spawn_ok  = fire_edge && (cooldown == 8'd0) && free_found;
        spawn_vec = spawn_ok ? free_vec : '0;

        kill_vec   = '0;
        bounce_vec = '0;
        // Eligibility looks at the already-decremented holdoff, so a bounce at
        // frame k allows the next one at frame k+BOUNCE_HOLDOFF.
        for (int i = 0; i < NUM_BULLETS; i++) begin
            hold_eff[i]   = (holdoff[i] == '0) ? '0 : holdoff[i] - HOLD_W'(1);
            kill_vec[i]   = bulletExists[i] &&
                            (abs_diff(bulletPosX[10*i +: 10], enemyPosX) <= {3'b000, enemyRadius}) &&
                            (abs_diff(bulletPosY[10*i +: 10], enemyPosY) <= {3'b000, enemyRadius});
            bounce_vec[i] = bulletExists[i] && !kill_vec[i] && (hold_eff[i] == '0) &&
                            at_limit(bulletPosX[10*i +: 10], bulletPosY[10*i +: 10]);
        end

        start_x = tankPosX;
        start_y = tankPosY;
        case (tankDir)
            DIR_UP:    start_y = tankPosY - SPAWN_OFFSET;
            DIR_DOWN:  start_y = tankPosY + SPAWN_OFFSET;
            DIR_LEFT:  start_x = tankPosX - SPAWN_OFFSET;
            default:   start_x = tankPosX + SPAWN_OFFSET;
        endcase
    end

    always_ff @(posedge frameClk or negedge resetN) begin
        if (!resetN) begin
            // Edge register resets high so a button held through reset is ignored.
            fire_q         <= 1'b1;
            fire_prev      <= 1'b1;
            cooldown       <= 8'd0;
            sigSpawn       <= '0;
            sigBounce      <= '0;
            sigKill        <= '0;
            bulletStartX   <= 10'd0;
            bulletStartY   <= 10'd0;
            bulletStartDir <= DIR_RIGHT;
            hitPulse       <= 1'b0;
            fireDropped    <= 1'b0;
            hitCount       <= 8'd0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                holdoff[i]  <= '0;
                pend_cnt[i] <= 2'd0;
            end
        end else begin
            fire_prev   <= fire_q;
            fire_q      <= fireReq;
            sigSpawn    <= spawn_vec;
            sigBounce   <= bounce_vec;
            sigKill     <= kill_vec;
            hitPulse    <= |kill_vec;
            fireDropped <= fire_edge && !spawn_ok;
            if (|kill_vec) begin
                hitCount <= sat_inc(hitCount);
            end
            if (spawn_ok) begin
                cooldown       <= COOLDOWN;
                bulletStartX   <= start_x;
                bulletStartY   <= start_y;
                bulletStartDir <= tankDir;
            end else if (cooldown != 8'd0) begin
                cooldown <= cooldown - 8'd1;
            end
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (kill_vec[i]) begin
                    holdoff[i] <= '0;
                end else if (bounce_vec[i]) begin
                    holdoff[i] <= HOLD_INIT;
                end else begin
                    holdoff[i] <= hold_eff[i];
                end
                if (spawn_vec[i]) begin
                    pend_cnt[i] <= 2'd2;
                end else if (bulletExists[i]) begin
                    pend_cnt[i] <= 2'd0;
                end else if (pend_cnt[i] != 2'd0) begin
                    pend_cnt[i] <= pend_cnt[i] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bullet_controller.sv
// Scoreboard bench for bullet_controller: a frame-level reference model predicts
// every frame's outputs, and a monitor compares them one frame after each edge.
module tb_bullet_controller;

    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

    logic        frameClk;
    logic        resetN;
    logic        fireReq;
    logic [9:0]  tankPosX, tankPosY;
    logic [1:0]  tankDir;
    logic [3:0]  bulletExists;
    logic [39:0] bulletPosX, bulletPosY;
    logic [9:0]  enemyPosX, enemyPosY;
    logic [7:0]  enemyRadius;
    logic [3:0]  sigSpawn, sigBounce, sigKill;
    logic [9:0]  bulletStartX, bulletStartY;
    logic [1:0]  bulletStartDir;
    logic        hitPulse, fireDropped;
    logic [7:0]  hitCount;

    bullet_controller dut (
        .frameClk(frameClk), .resetN(resetN), .fireReq(fireReq),
        .tankPosX(tankPosX), .tankPosY(tankPosY), .tankDir(tankDir),
        .bulletExists(bulletExists), .bulletPosX(bulletPosX), .bulletPosY(bulletPosY),
        .enemyPosX(enemyPosX), .enemyPosY(enemyPosY), .enemyRadius(enemyRadius),
        .sigSpawn(sigSpawn), .sigBounce(sigBounce), .sigKill(sigKill),
        .bulletStartX(bulletStartX), .bulletStartY(bulletStartY),
        .bulletStartDir(bulletStartDir), .hitPulse(hitPulse),
        .fireDropped(fireDropped), .hitCount(hitCount)
    );

    typedef struct {
        logic [3:0] spawn, bounce, kill;
        logic       hit, drop;
        int         hits, sx, sy, sdir;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state, kept as frame numbers rather than counters.
    int m_frame, m_last, m_prev, m_last_spawn, m_hits, m_sx, m_sy, m_sdir;
    int m_bounce_frame[4];
    int m_spawn_frame[4];
    bit m_seen[4];

    initial begin
        frameClk = 1'b0;
        forever #5 frameClk = ~frameClk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrap10(input int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    task automatic model_reset();
        m_frame = 0; m_last = 1; m_prev = 1; m_last_spawn = -1000; m_hits = 0;
        m_sx = 0; m_sy = 0; m_sdir = RIGHT;
        for (int i = 0; i < 4; i++) begin
            m_bounce_frame[i] = -1000;
            m_spawn_frame[i]  = -1000;
            m_seen[i]         = 1'b1;
        end
    endtask

    function automatic bit pending(input int i);
        int d;
        d = m_frame - m_spawn_frame[i];
        return (d == 1 || d == 2) && !m_seen[i];
    endfunction

    task automatic model_step();
        exp_t e;
        int   px, py, dx, dy, free, tx, ty;
        bit   rise, any_kill;
        e.spawn = '0; e.bounce = '0; e.kill = '0; e.hit = 1'b0; e.drop = 1'b0;
        rise   = (m_last == 1) && (m_prev == 0);
        m_prev = m_last;
        m_last = int'(fireReq);
        any_kill = 1'b0;
        for (int i = 0; i < 4; i++) begin
            px = int'(bulletPosX[10*i +: 10]);
            py = int'(bulletPosY[10*i +: 10]);
            dx = px - int'(enemyPosX); if (dx < 0) dx = -dx;
            dy = py - int'(enemyPosY); if (dy < 0) dy = -dy;
            if (bulletExists[i] && dx <= int'(enemyRadius) && dy <= int'(enemyRadius)) begin
                e.kill[i] = 1'b1;
                any_kill  = 1'b1;
                m_bounce_frame[i] = -1000;
            end else if (bulletExists[i] && (m_frame - m_bounce_frame[i]) >= 3 &&
                         (px <= 8 || px >= 631 || py <= 8 || py >= 471)) begin
                e.bounce[i] = 1'b1;
                m_bounce_frame[i] = m_frame;
            end
        end
        if (any_kill) begin
            e.hit = 1'b1;
            if (m_hits < 255) m_hits++;
        end
        free = -1;
        for (int i = 3; i >= 0; i--) if (!bulletExists[i] && !pending(i)) free = i;
        if (rise) begin
            if ((m_frame - m_last_spawn) <= 15 || free < 0) begin
                e.drop = 1'b1;
            end else begin
                e.spawn[free] = 1'b1;
                m_spawn_frame[free] = m_frame;
                m_seen[free] = 1'b0;
                m_last_spawn = m_frame;
                tx = int'(tankPosX); ty = int'(tankPosY);
                case (int'(tankDir))
                    UP:      ty = ty - 12;
                    DOWN:    ty = ty + 12;
                    LEFT:    tx = tx - 12;
                    default: tx = tx + 12;
                endcase
                m_sx = wrap10(tx); m_sy = wrap10(ty); m_sdir = int'(tankDir);
            end
        end
        for (int i = 0; i < 4; i++) if (bulletExists[i]) m_seen[i] = 1'b1;
        e.hits = m_hits; e.sx = m_sx; e.sy = m_sy; e.sdir = m_sdir;
        m_frame++;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge frameClk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mon_sigSpawn", int'(sigSpawn), int'(e.spawn));
                chk("mon_sigBounce", int'(sigBounce), int'(e.bounce));
                chk("mon_sigKill", int'(sigKill), int'(e.kill));
                chk("mon_hitPulse", int'(hitPulse), int'(e.hit));
                chk("mon_fireDropped", int'(fireDropped), int'(e.drop));
                chk("mon_hitCount", int'(hitCount), e.hits);
                chk("mon_startX", int'(bulletStartX), e.sx);
                chk("mon_startY", int'(bulletStartY), e.sy);
                chk("mon_startDir", int'(bulletStartDir), e.sdir);
            end
        end
    end

    task automatic cycle();
        model_step();
        @(posedge frameClk);
        #2;
    endtask

    task automatic fire_pulse();
        fireReq = 1'b1;
        cycle();
        fireReq = 1'b0;
        cycle();
    endtask

    task automatic set_pos(input int i, input int x, input int y);
        bulletPosX[10*i +: 10] = 10'(x);
        bulletPosY[10*i +: 10] = 10'(y);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_spawn"}, int'(sigSpawn), 0);
        chk({tag, "_bounce"}, int'(sigBounce), 0);
        chk({tag, "_kill"}, int'(sigKill), 0);
        chk({tag, "_hitPulse"}, int'(hitPulse), 0);
        chk({tag, "_dropped"}, int'(fireDropped), 0);
        chk({tag, "_hitCount"}, int'(hitCount), 0);
        chk({tag, "_startX"}, int'(bulletStartX), 0);
        chk({tag, "_startY"}, int'(bulletStartY), 0);
        chk({tag, "_startDir"}, int'(bulletStartDir), RIGHT);
    endtask

    function automatic int pick(input int hi, input int en);
        int v;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 1023));
            1:       v = int'($urandom_range(0, 15));
            2:       v = hi - 6 + int'($urandom_range(0, 12));
            default: v = en - 30 + int'($urandom_range(0, 60));
        endcase
        return wrap10(v);
    endfunction

    initial begin
        int         spawns;
        logic [3:0] bexp [4];
        resetN = 1'b0; fireReq = 1'b0;
        tankPosX = 10'd100; tankPosY = 10'd200; tankDir = 2'(RIGHT);
        bulletExists = 4'b0000;
        for (int i = 0; i < 4; i++) set_pos(i, 320, 240);
        enemyPosX = 10'd50; enemyPosY = 10'd50; enemyRadius = 8'd4;
        model_reset();
        repeat (3) @(posedge frameClk);
        #2;
        check_idle_outputs("reset");
        resetN = 1'b1;

        // First shot from (100,200) facing right; holding the button fires once.
        cycle();
        fireReq = 1'b1;
        cycle();
        cycle();
        chk("first_spawn", int'(sigSpawn), 4'b0001);
        chk("first_startX", int'(bulletStartX), 112);
        chk("first_startY", int'(bulletStartY), 200);
        chk("first_startDir", int'(bulletStartDir), RIGHT);
        bulletExists = 4'b0001;
        spawns = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (sigSpawn != 4'b0000) spawns++;
        end
        chk("held_no_respawn", spawns, 0);

        // Cooldown: edge, edge 5 frames later dropped, edge 16 frames later spawns.
        fireReq = 1'b0;
        cycle();
        fire_pulse();
        chk("cd_first_spawn", int'(sigSpawn), 4'b0010);
        bulletExists = 4'b0011;
        repeat (3) cycle();
        fire_pulse();
        chk("cd_drop_flag", int'(fireDropped), 1);
        chk("cd_drop_nospawn", int'(sigSpawn), 0);
        repeat (9) cycle();
        fire_pulse();
        chk("cd_after_spawn", int'(sigSpawn), 4'b0100);
        chk("cd_after_nodrop", int'(fireDropped), 0);
        bulletExists = 4'b0111;

        // Pool full, then slot 2 frees up.
        bulletExists = 4'b1111;
        repeat (16) cycle();
        fire_pulse();
        chk("full_drop_flag", int'(fireDropped), 1);
        chk("full_nospawn", int'(sigSpawn), 0);
        bulletExists = 4'b1011;
        repeat (16) cycle();
        fire_pulse();
        chk("freed_slot2", int'(sigSpawn), 4'b0100);

        // Slot 1 parked on the right wall for four frames.
        bulletExists = 4'b0010;
        set_pos(1, 631, 240);
        bexp[0] = 4'b0010; bexp[1] = 4'b0000; bexp[2] = 4'b0000; bexp[3] = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("wall_bounce", int'(sigBounce), int'(bexp[k]));
        end
        set_pos(1, 320, 240);

        // Kill beats bounce, then hit count saturates.
        bulletExists = 4'b0001;
        set_pos(0, 8, 100);
        enemyPosX = 10'd8; enemyPosY = 10'd100; enemyRadius = 8'd5;
        cycle();
        chk("kill_vec", int'(sigKill), 4'b0001);
        chk("kill_nobounce", int'(sigBounce), 0);
        chk("kill_hitPulse", int'(hitPulse), 1);
        chk("kill_hitCount", int'(hitCount), 1);
        repeat (300) cycle();
        chk("hitcount_sat", int'(hitCount), 255);
        enemyPosX = 10'd50; enemyPosY = 10'd50; enemyRadius = 8'd4;
        set_pos(0, 320, 240);

        // Upward shot near the origin wraps the start Y.
        bulletExists = 4'b0000;
        tankPosX = 10'd5; tankPosY = 10'd5; tankDir = 2'(UP);
        repeat (16) cycle();
        fire_pulse();
        chk("wrap_spawn", int'(sigSpawn), 4'b0001);
        chk("wrap_startX", int'(bulletStartX), 5);
        chk("wrap_startY", int'(bulletStartY), 1017);
        chk("wrap_startDir", int'(bulletStartDir), UP);

        // Asynchronous reset in the middle of cooldown.
        repeat (3) cycle();
        resetN = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        model_reset();
        repeat (2) @(posedge frameClk);
        #2;
        resetN = 1'b1;
        cycle();
        fire_pulse();
        chk("post_reset_spawn", int'(sigSpawn), 4'b0001);
        chk("post_reset_nodrop", int'(fireDropped), 0);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 2) == 0) fireReq = ~fireReq;
            if ($urandom_range(0, 3) == 0) bulletExists = 4'($urandom_range(0, 15));
            tankDir   = 2'($urandom_range(0, 3));
            tankPosX  = 10'($urandom_range(0, 1023));
            tankPosY  = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) begin
                enemyPosX   = 10'($urandom_range(0, 1023));
                enemyPosY   = 10'($urandom_range(0, 1023));
                enemyRadius = 8'($urandom_range(0, 40));
            end
            for (int i = 0; i < 4; i++)
                set_pos(i, pick(631, int'(enemyPosX)), pick(471, int'(enemyPosY)));
            cycle();
        end

        @(posedge frameClk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
